seg7_scan_ctrl: RTL

- Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment display.
- All digits share one seg7_decode instance: this block presents one BCD nibble at a time on oBCD and drives the matching active-low digit enable.
- Host writes a packed BCD value through a valid/ready handshake. The value is committed only at a frame boundary, so no mixed old/new frame is ever displayed.
- Inserts a dark gap between digits to prevent ghosting, and optionally blanks leading zeros.

---
 rtl/seg7_scan_ctrl_if.sv | 15 +
 rtl/seg7_scan_ctrl.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl_if.sv
// Host write channel for seg7_scan_ctrl.
//   iDATA  : packed BCD value, nibble i belongs to digit i
//   iVALID : host offers iDATA
//   oREADY : controller can take iDATA
// master = host side, slave = scan controller side.
interface seg7_scan_ctrl_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] iDATA;
  logic                iVALID;
  logic                oREADY;

  modport master (output iDATA, output iVALID, input oREADY);
  modport slave  (input iDATA, input iVALID, output oREADY);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// One BCD nibble is presented at a time on oBCD (for a shared decoder) with
// the matching active-low digit enable. Host values are staged in a pending
// register and only committed to the display at a frame boundary, so a frame
// never mixes old and new digits. A dark gap precedes each lit digit, and
// leading zeros can optionally be blanked.
// Ports:
//   iCLK, iRST : clock, synchronous active-high reset
//   iEN        : scan enable, low forces the display dark
//   bus        : host write channel (iDATA / iVALID / oREADY)
//   oBCD       : nibble to the decoder, 4'hF = blank
//   oDIG_N     : active-low digit enables, at most one low
//   oFRAME     : one-cycle pulse at each frame boundary
module seg7_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 1000,
  parameter int BLANK  = 16,
  parameter int LZB    = 1
) (
  input  logic                  iCLK,
  input  logic                  iRST,
  input  logic                  iEN,
  seg7_scan_ctrl_if.slave       bus,
  output logic [3:0]            oBCD,
  output logic [DIGITS-1:0]     oDIG_N,
  output logic                  oFRAME
);

  localparam int CMAX0 = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CMAX  = (CMAX0 > 2) ? CMAX0 : 2;
  localparam int CW    = $clog2(CMAX);
  localparam int IW    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CW-1:0] DW_LAST  = CW'(DWELL - 1);
  localparam logic [CW-1:0] BL_LAST  = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [4*DIGITS-1:0] disp_q, disp_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic                ready_q, ready_d;
  logic [3:0]          bcd_q, bcd_d;
  logic [DIGITS-1:0]   dig_n_q, dig_n_d;
  logic                frame_q, frame_d;
  logic                xfer, commit;

  // Nibble actually shown for digit i: blanked when it and all higher
  // nibbles are zero (digit 0 is always shown).
  function automatic logic [3:0] eff_nib(input logic [4*DIGITS-1:0] v,
                                         input logic [IW-1:0]       i);
    logic [3:0] nib;
    logic       hi_zero;
    nib     = 4'h0;
    hi_zero = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == i) nib = v[4*k +: 4];
      if ((IW'(k) >= i) && (v[4*k +: 4] != 4'h0)) hi_zero = 1'b0;
    end
    if ((LZB != 0) && (i != '0) && hi_zero) return 4'hF;
    return nib;
  endfunction

  // State register plus registered outputs and data registers
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      pend_q  <= '0;
      ready_q <= 1'b1;
      bcd_q   <= 4'hF;
      dig_n_q <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      bcd_q   <= bcd_d;
      dig_n_q <= dig_n_d;
      frame_q <= frame_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (!iEN) begin
      state_d = ST_BLANK;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_BLANK: begin
          // With BLANK=0 this state is only ever entered from reset or
          // disable, and is left on the first enabled edge.
          if ((BLANK == 0) || (cnt_q == BL_LAST)) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          if (cnt_q == DW_LAST) begin
            cnt_d   = '0;
            state_d = (BLANK == 0) ? ST_SHOW : ST_BLANK;
            if (idx_q == IDX_LAST) begin
              idx_d   = '0;
              frame_d = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase
    end
  end

  // Handshake and commit. A pending value exists exactly when ready is low,
  // so a transfer and a commit can never coincide on the same value. While
  // disabled the display is dark, so pending data commits at once.
  always_comb begin
    xfer    = bus.iVALID & ready_q;
    commit  = (frame_d | ~iEN) & ~ready_q;
    disp_d  = commit ? pend_q : disp_q;
    pend_d  = xfer ? bus.iDATA : pend_q;
    ready_d = ready_q;
    if (commit) ready_d = 1'b1;
    if (xfer)   ready_d = 1'b0;
  end

  // Output logic, decoded from the next state so the registered pins line
  // up with the state register.
  always_comb begin
    bcd_d   = 4'hF;
    dig_n_d = '1;
    if (state_d == ST_SHOW) begin
      dig_n_d[idx_d] = 1'b0;
      bcd_d          = eff_nib(disp_d, idx_d);
    end
  end

  assign bus.oREADY = ready_q;
  assign oBCD       = bcd_q;
  assign oDIG_N     = dig_n_q;
  assign oFRAME     = frame_q;

endmodule
